// File: rtl/idu_rf_pipe_fwd.sv
// Register-read / operand-forwarding stage between issue and an execution pipe.
// Operands resolve from capture, bypass (lowest index wins) or RF, and are frozen while stalled.
module idu_rf_pipe_fwd #(
    parameter int XLEN   = 64,
    parameter int PREG_W = 6,
    parameter int IID_W  = 4,
    parameter int NSRC   = 2,
    parameter int NFWD   = 8
) (
    input  logic                     clk,
    input  logic                     rst_clk,
    input  logic                     rtu_global_flush,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [IID_W-1:0]         in_iid,
    input  logic [6:0]               in_opcode,
    input  logic [6:0]               in_funct7,
    input  logic [2:0]               in_funct3,
    input  logic [63:0]              in_pc,
    input  logic [NSRC-1:0]          in_psrc_vld,
    input  logic [NSRC*PREG_W-1:0]   in_psrc,
    input  logic                     in_pdst_vld,
    input  logic [PREG_W-1:0]        in_pdst,
    input  logic                     in_imm_vld,
    input  logic [XLEN-1:0]          in_imm,
    input  logic [NFWD-1:0]          fwd_vld,
    input  logic [NFWD*PREG_W-1:0]   fwd_preg,
    input  logic [NFWD*XLEN-1:0]     fwd_result,
    output logic [NSRC*PREG_W-1:0]   rf_rd_preg,
    input  logic [NSRC*XLEN-1:0]     rf_rd_value,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [IID_W-1:0]         out_iid,
    output logic [6:0]               out_opcode,
    output logic [6:0]               out_funct7,
    output logic [2:0]               out_funct3,
    output logic [63:0]              out_pc,
    output logic [NSRC-1:0]          out_psrc_vld,
    output logic [NSRC*XLEN-1:0]     out_psrc_value,
    output logic                     out_pdst_vld,
    output logic [PREG_W-1:0]        out_pdst,
    output logic                     out_imm_vld,
    output logic [XLEN-1:0]          out_imm
);

    logic [NSRC*PREG_W-1:0] psrc_q;
    logic [NSRC-1:0]        cap_flag;
    logic [NSRC*XLEN-1:0]   cap_value;
    logic                   accept;
    logic                   xfer;
    logic                   stall;

    assign in_rdy     = !out_vld || out_rdy;
    assign accept     = in_vld && in_rdy;
    assign xfer       = out_vld && out_rdy;
    assign stall      = out_vld && !out_rdy;
    assign rf_rd_preg = psrc_q;

    // Descending scan so the lowest-index matching bypass overwrites any higher one.
    always_comb begin
        out_psrc_value = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (out_psrc_vld[s]) begin
                if (cap_flag[s]) begin
                    out_psrc_value[s*XLEN +: XLEN] = cap_value[s*XLEN +: XLEN];
                end else begin
                    out_psrc_value[s*XLEN +: XLEN] = rf_rd_value[s*XLEN +: XLEN];
                    for (int k = NFWD - 1; k >= 0; k--) begin
                        if (fwd_vld[k] && (fwd_preg[k*PREG_W +: PREG_W] == psrc_q[s*PREG_W +: PREG_W])) begin
                            out_psrc_value[s*XLEN +: XLEN] = fwd_result[k*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            out_vld      <= 1'b0;
            out_iid      <= '0;
            out_opcode   <= '0;
            out_funct7   <= '0;
            out_funct3   <= '0;
            out_pc       <= '0;
            out_psrc_vld <= '0;
            psrc_q       <= '0;
            out_pdst_vld <= 1'b0;
            out_pdst     <= '0;
            out_imm_vld  <= 1'b0;
            out_imm      <= '0;
            cap_flag     <= '0;
            cap_value    <= '0;
        end else if (rtu_global_flush || (xfer && !accept)) begin
            out_vld      <= 1'b0;
            out_iid      <= '0;
            out_opcode   <= '0;
            out_funct7   <= '0;
            out_funct3   <= '0;
            out_pc       <= '0;
            out_psrc_vld <= '0;
            psrc_q       <= '0;
            out_pdst_vld <= 1'b0;
            out_pdst     <= '0;
            out_imm_vld  <= 1'b0;
            out_imm      <= '0;
            cap_flag     <= '0;
            cap_value    <= '0;
        end else if (accept) begin
            out_vld      <= 1'b1;
            out_iid      <= in_iid;
            out_opcode   <= in_opcode;
            out_funct7   <= in_funct7;
            out_funct3   <= in_funct3;
            out_pc       <= in_pc;
            out_psrc_vld <= in_psrc_vld;
            psrc_q       <= in_psrc;
            out_pdst_vld <= in_pdst_vld;
            out_pdst     <= in_pdst;
            out_imm_vld  <= in_imm_vld;
            out_imm      <= in_imm;
            cap_flag     <= '0;
            cap_value    <= '0;
        end else if (stall) begin
            // First stalled cycle freezes each operand; later bypass traffic is ignored.
            for (int s = 0; s < NSRC; s++) begin
                if (!cap_flag[s]) begin
                    cap_flag[s]                  <= 1'b1;
                    cap_value[s*XLEN +: XLEN]    <= out_psrc_value[s*XLEN +: XLEN];
                end
            end
        end
    end

endmodule
